// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | aes_key_schedule_seq : iterative AES-128/192/256 key expansion, 1 word/clk |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
module aes_key_schedule_seq #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic                start_ready_o,
  input  logic [1:0]          key_len_i,
  input  logic [255:0]        key_in_i,
  output logic                bad_mode_o,
  output logic                busy_o,
  output logic                keys_valid_o,
  input  logic                rk_rd_en_i,
  input  logic [RK_IDX_W-1:0] rk_idx_i,
  output logic [127:0]        rk_out_o,
  output logic                rk_out_valid_o,
  output logic                rk_err_o
);
  localparam int MAX_NK    = MAX_KEY_BITS / 32;
  localparam int MAX_NR    = MAX_NK + 6;
  localparam int MAX_WORDS = 4 * (MAX_NR + 1);
  localparam int IDX_W     = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as x^254 (repeated squaring), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t           state_q;
  logic             start_ready_q, busy_q, keys_valid_q, bad_mode_q;
  logic             rk_out_valid_q, rk_err_q;
  logic [127:0]     rk_out_q;
  logic [255:0]     key_q;
  logic [1:0]       key_len_q;
  logic [IDX_W-1:0] i_q;
  logic [2:0]       mod_q;
  logic [7:0]       rcon_q;
  logic [31:0]      w_q [MAX_WORDS];

  logic [3:0]       nk, nr;
  logic [IDX_W-1:0] tot_last;
  logic             len_ok, rd_ok;
  logic [IDX_W-1:0] rd_base;
  logic [31:0]      prev_w, far_w, rot_w, sub_in, sub_out, temp_d, word_d;

  always_comb begin
    nk       = 4'd4;
    nr       = 4'd10;
    tot_last = IDX_W'(43);
    case (key_len_q)
      2'd1:    begin nk = 4'd6; nr = 4'd12; tot_last = IDX_W'(51); end
      2'd2:    begin nk = 4'd8; nr = 4'd14; tot_last = IDX_W'(59); end
      default: ;
    endcase
  end

  assign len_ok  = (key_len_i != 2'd3) && ((128 + 64 * int'(key_len_i)) <= MAX_KEY_BITS);
  assign rd_ok   = keys_valid_q && (32'(rk_idx_i) <= 32'(nr));
  assign rd_base = IDX_W'({rk_idx_i, 2'b00});

  assign prev_w = w_q[i_q - IDX_W'(1)];
  assign far_w  = w_q[i_q - IDX_W'(nk)];
  assign rot_w  = {prev_w[23:0], prev_w[31:24]};
  assign sub_in = (mod_q == 3'd0) ? rot_w : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
  end

  always_comb begin
    temp_d = prev_w;
    if (mod_q == 3'd0)                      temp_d = sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && mod_q == 3'd4)   temp_d = sub_out;
    word_d = far_w ^ temp_d;
  end

  // Storage is deliberately not reset; keys_valid gates every read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_LOAD) begin
        for (int j = 0; j < MAX_NK; j++)
          if (j < int'(nk)) w_q[j] <= key_q[255 - 32*j -: 32];
      end else if (state_q == S_EXPAND) begin
        w_q[i_q] <= word_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      keys_valid_q   <= 1'b0;
      bad_mode_q     <= 1'b0;
      rk_out_valid_q <= 1'b0;
      rk_err_q       <= 1'b0;
      rk_out_q       <= '0;
      key_q          <= '0;
      key_len_q      <= 2'd0;
      i_q            <= '0;
      mod_q          <= 3'd0;
      rcon_q         <= 8'h01;
    end else begin
      bad_mode_q     <= 1'b0;
      rk_out_valid_q <= 1'b0;
      rk_err_q       <= 1'b0;
      if (rk_rd_en_i) begin
        if (rd_ok) begin
          rk_out_q       <= {w_q[rd_base], w_q[rd_base + IDX_W'(1)],
                             w_q[rd_base + IDX_W'(2)], w_q[rd_base + IDX_W'(3)]};
          rk_out_valid_q <= 1'b1;
        end else begin
          rk_err_q <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            if (len_ok) begin
              key_len_q     <= key_len_i;
              key_q         <= key_in_i;
              keys_valid_q  <= 1'b0;
              start_ready_q <= 1'b0;
              busy_q        <= 1'b1;
              state_q       <= S_LOAD;
            end else begin
              bad_mode_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          i_q     <= IDX_W'(nk);
          mod_q   <= 3'd0;
          rcon_q  <= 8'h01;
          state_q <= S_EXPAND;
        end
        S_EXPAND: begin
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
          mod_q <= ({1'b0, mod_q} == nk - 4'd1) ? 3'd0 : mod_q + 3'd1;
          i_q   <= i_q + IDX_W'(1);
          if (i_q == tot_last) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            keys_valid_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready_o  = start_ready_q;
  assign busy_o         = busy_q;
  assign keys_valid_o   = keys_valid_q;
  assign bad_mode_o     = bad_mode_q;
  assign rk_out_o       = rk_out_q;
  assign rk_out_valid_o = rk_out_valid_q;
  assign rk_err_o       = rk_err_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_aes_key_schedule_seq : FIPS-197 vectors, corner sequences, random keys |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
module tb_aes_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst, start, start_ready, bad_mode, busy, keys_valid;
  logic         rk_rd_en, rk_out_valid, rk_err;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int checks = 0;
  int errors = 0;

  aes_key_schedule_seq #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .start_ready_o(start_ready),
    .key_len_i(key_len), .key_in_i(key_in), .bad_mode_o(bad_mode), .busy_o(busy),
    .keys_valid_o(keys_valid), .rk_rd_en_i(rk_rd_en), .rk_idx_i(rk_idx),
    .rk_out_o(rk_out), .rk_out_valid_o(rk_out_valid), .rk_err_o(rk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: FIPS-197 key expansion over plain arrays
  logic [7:0]  sb [256];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] m_w [60];
  int          m_nr, m_lat;

  function automatic int tb_gmul(input int a, input int b);
    int p, x;
    p = 0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (((b >> k) & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11b;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (tb_gmul(x, y) == 1) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic void model_expand(input logic [1:0] len, input logic [255:0] key);
    int nk, tot;
    logic [31:0] t;
    nk    = 4 + 2 * int'(len);
    m_nr  = nk + 6;
    tot   = 4 * (m_nr + 1);
    m_lat = 2 + tot - nk;
    for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < tot; i++) begin
      t = m_w[i-1];
      if (i % nk == 0)                 t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      m_w[i] = m_w[i-nk] ^ t;
    end
  endfunction

  function automatic logic [127:0] m_rk(input int r);
    return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
  endfunction

  task automatic read_rk(input int idx, output logic v, output logic e, output logic [127:0] d);
    rk_rd_en = 1'b1;
    rk_idx   = 4'(idx);
    @(negedge clk);
    rk_rd_en = 1'b0;
    v = rk_out_valid;
    e = rk_err;
    d = rk_out;
  endtask

  // Starts an expansion; dis_kind 1 = stray start at T+dis_at, 2 = reset at T+dis_at.
  // lat returns the cycle offset at which keys_valid was first seen, or -1 if reset aborted.
  task automatic run_expand(input logic [1:0] len, input logic [255:0] key,
                            input int dis_at, input int dis_kind,
                            input int rd_same, input logic [127:0] rd_exp, output int lat);
    start   = 1'b1;
    key_len = len;
    key_in  = key;
    if (rd_same >= 0) begin
      rk_rd_en = 1'b1;
      rk_idx   = 4'(rd_same);
    end
    @(negedge clk);
    start    = 1'b0;
    rk_rd_en = 1'b0;
    key_in   = ~key;
    if (rd_same >= 0) begin
      chk_b("rd_at_start_valid", rk_out_valid, 1'b1);
      chk_w("rd_at_start_data", rk_out, rd_exp);
    end
    chk_b("busy_after_start", busy, 1'b1);
    chk_b("kv_cleared_after_start", keys_valid, 1'b0);
    lat = 1;
    while (!keys_valid && lat < 200) begin
      if (lat == dis_at && dis_kind == 1) begin
        chk_b("start_ready_while_busy", start_ready, 1'b0);
        start   = 1'b1;
        key_len = 2'd2;
        key_in  = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (lat == dis_at && dis_kind == 2) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        chk_b("rst_mid_kv", keys_valid, 1'b0);
        chk_b("rst_mid_busy", busy, 1'b0);
        chk_b("rst_mid_ready", start_ready, 1'b1);
        lat = -1;
        return;
      end
      lat++;
    end
  endtask

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           idx;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  localparam logic [255:0] KEY_A1 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A2 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
  localparam logic [255:0] KEY_A3 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  vec_t vecs [7];

  initial begin
    logic         v, e;
    logic [127:0] d, prev;
    int           lat;
    logic [1:0]   rlen;
    logic [255:0] rkey;

    vecs[0] = '{2'd1, KEY_A2, 12, 128'he98ba06f_448c773c_8ecc7204_01002202, 48};
    vecs[1] = '{2'd2, KEY_A3, 14, 128'hfe4890d1_e6188d0b_046df344_706c631e, 54};
    vecs[2] = '{2'd2, KEY_A3, 0,  128'h603deb10_15ca71be_2b73aef0_857d7781, 54};
    vecs[3] = '{2'd2, KEY_A3, 1,  128'h1f352c07_3b6108d7_2d9810a3_0914dff4, 54};
    vecs[4] = '{2'd0, KEY_A1, 0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 42};
    vecs[5] = '{2'd0, KEY_A1, 10, A1_RK10, 42};
    vecs[6] = '{2'd0, KEY_A1, 1,  A1_RK1,  42};

    build_sbox();
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rk_rd_en = 1'b0; rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    chk_b("reset_start_ready", start_ready, 1'b1);
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_keys_valid", keys_valid, 1'b0);
    chk_b("reset_bad_mode", bad_mode, 1'b0);
    chk_b("reset_rk_out_valid", rk_out_valid, 1'b0);
    chk_b("reset_rk_err", rk_err, 1'b0);
    chk_w("reset_rk_out", rk_out, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    read_rk(0, v, e, d);
    chk_b("read_before_valid_err", e, 1'b1);
    chk_b("read_before_valid_vld", v, 1'b0);

    start = 1'b1; key_len = 2'd3; key_in = KEY_A1;
    @(negedge clk);
    start = 1'b0;
    chk_b("bad_mode_pulse", bad_mode, 1'b1);
    chk_b("bad_mode_ready", start_ready, 1'b1);
    chk_b("bad_mode_busy", busy, 1'b0);
    chk_b("bad_mode_kv", keys_valid, 1'b0);
    @(negedge clk);
    chk_b("bad_mode_one_cycle", bad_mode, 1'b0);

    for (int n = 0; n < 7; n++) begin
      run_expand(vecs[n].len, vecs[n].key, -1, 0, -1, 128'h0, lat);
      chk_i($sformatf("vec%0d_latency", n), lat, vecs[n].lat);
      read_rk(vecs[n].idx, v, e, d);
      chk_b($sformatf("vec%0d_valid", n), v, 1'b1);
      chk_w($sformatf("vec%0d_rk", n), d, vecs[n].exp);
    end

    read_rk(11, v, e, d);
    chk_b("idx11_128_err", e, 1'b1);
    chk_b("idx11_128_vld", v, 1'b0);
    chk_w("idx11_rk_out_held", d, A1_RK1);

    start = 1'b1; key_len = 2'd3;
    @(negedge clk);
    start = 1'b0;
    chk_b("bad_mode_done_pulse", bad_mode, 1'b1);
    chk_b("bad_mode_done_kv", keys_valid, 1'b1);
    chk_b("bad_mode_done_busy", busy, 1'b0);

    run_expand(2'd0, KEY_A1, 10, 1, -1, 128'h0, lat);
    chk_i("busy_start_latency", lat, 42);
    read_rk(10, v, e, d);
    chk_w("busy_start_idx10", d, A1_RK10);
    read_rk(1, v, e, d);
    chk_w("busy_start_idx1", d, A1_RK1);

    run_expand(2'd2, KEY_A3, 20, 2, 10, A1_RK10, lat);
    chk_i("rst_abort", lat, -1);
    read_rk(0, v, e, d);
    chk_b("after_rst_read_err", e, 1'b1);

    run_expand(2'd2, KEY_A3, -1, 0, -1, 128'h0, lat);
    chk_i("restart_a3_latency", lat, 54);
    read_rk(14, v, e, d);
    chk_w("restart_a3_idx14", d, 128'hfe4890d1_e6188d0b_046df344_706c631e);

    for (int it = 0; it < 6; it++) begin
      rlen = 2'($urandom_range(0, 2));
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(rlen, rkey);
      run_expand(rlen, rkey, -1, 0, -1, 128'h0, lat);
      chk_i($sformatf("rand%0d_latency", it), lat, m_lat);
      prev = rk_out;
      for (int r = 0; r <= m_nr + 1; r++) begin
        rk_rd_en = 1'b1;
        rk_idx   = 4'(r);
        @(negedge clk);
        if (r <= m_nr) begin
          chk_b($sformatf("rand%0d_idx%0d_valid", it, r), rk_out_valid, 1'b1);
          chk_w($sformatf("rand%0d_idx%0d_rk", it, r), rk_out, m_rk(r));
          prev = m_rk(r);
        end else begin
          chk_b($sformatf("rand%0d_idx%0d_err", it, r), rk_err, 1'b1);
          chk_w($sformatf("rand%0d_idx%0d_held", it, r), rk_out, prev);
        end
      end
      rk_rd_en = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
